mul: RTL and testbench

// - Iterative shift-add integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU group; the multiply

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_if.sv | 27 ++
 rtl/mul.sv | 133 +++++++++++++
 tb/tb_mul.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types for the iterative shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_INIT = 2'd1,
        M_CALC = 2'd2,
        M_SIGN = 2'd3
    } mul_states_e;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_if
// Description : Request/stall handshake and operand bus of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_if #(
    parameter int N = 32
);
    logic [N-1:0] first_operand_i;
    logic [N-1:0] second_operand_i;
    logic         enable_i;
    logic [1:0]   op_i;
    logic         hold_o;
    logic [N-1:0] mul_result_o;

    modport master (
        output first_operand_i, second_operand_i, enable_i, op_i,
        input  hold_o, mul_result_o
    );

    modport slave (
        input  first_operand_i, second_operand_i, enable_i, op_i,
        output hold_o, mul_result_o
    );
endinterface : mul_if
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
// Module      : mul
// Description : Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Revision    : 1.0 - initial release
// ============================================================================
module mul
    import mul_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic clk,
    input  wire logic reset_n,
    mul_if.slave      bus
);
    localparam int CW = $clog2(N);

    mul_states_e    state_q, state_d;
    mul_op_e        op_q, op_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  counter_q, counter_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   mplr_q, mplr_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] product_q, product_d;

    mul_op_e        op_in;
    logic [N-1:0]   a, b;
    logic           sign_a, sign_b, start;
    logic [N:0]     sum;
    logic [2*N-1:0] magnitude;

    assign op_in  = mul_op_e'(bus.op_i);
    assign a      = bus.first_operand_i;
    assign b      = bus.second_operand_i;
    assign sign_a = a[N-1] & ((op_in == MULH) | (op_in == MULHSU));
    assign sign_b = b[N-1] & (op_in == MULH);
    // valid_q blocks a second start of the same instruction while enable_i stays high
    assign start  = bus.enable_i & ~busy_q & ~valid_q;

    assign sum       = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    assign magnitude = {acc_q, mplr_q};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        neg_d     = neg_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        product_d = product_q;

        if (!bus.enable_i) begin
            state_d = M_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                M_IDLE: begin
                    if (start) begin
                        op_d = op_in;
                        if ((a == '0) || (b == '0)) begin
                            product_d = '0;
                            valid_d   = 1'b1;
                        end else begin
                            mcand_d = sign_a ? -a : a;
                            mplr_d  = sign_b ? -b : b;
                            neg_d   = sign_a ^ sign_b;
                            busy_d  = 1'b1;
                            state_d = M_INIT;
                        end
                    end
                end
                M_INIT: begin
                    acc_d     = '0;
                    counter_d = '0;
                    state_d   = M_CALC;
                end
                M_CALC: begin
                    acc_d     = sum[N:1];
                    mplr_d    = {sum[0], mplr_q[N-1:1]};
                    counter_d = counter_q + 1'b1;
                    if (counter_q == CW'(N-1)) begin
                        state_d = M_SIGN;
                    end
                end
                M_SIGN: begin
                    product_d = neg_q ? -magnitude : magnitude;
                    busy_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = M_IDLE;
                end
                default: state_d = M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= M_IDLE;
            op_q      <= MUL;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            neg_q     <= 1'b0;
            counter_q <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            neg_q     <= neg_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    assign bus.hold_o       = start | busy_q;
    assign bus.mul_result_o = (op_q == MUL) ? product_q[N-1:0] : product_q[2*N-1:N];

endmodule : mul
`default_nettype wire

// File: tb/tb_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul
// Description : Self-checking bench for the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul;
    localparam int N = 32;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mul_if #(.N(N)) bus ();

    mul #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // Reference: full-width arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'd0 || b == 32'd0) ? 1 : N + 3;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 of cycle 0; returns latency in cycles until hold_o low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input bit scramble, output logic [31:0] res, output int lat);
        bus.first_operand_i  = a;
        bus.second_operand_i = b;
        bus.op_i             = op;
        bus.enable_i         = 1'b1;
        lat = 0;
        @(negedge clk);
        while (bus.hold_o === 1'b1 && lat < 100) begin
            step();
            if (scramble) begin
                bus.first_operand_i  = $urandom;
                bus.second_operand_i = $urandom;
                bus.op_i             = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            lat++;
        end
        res = bus.mul_result_o;
    endtask

    task automatic release_op();
        step();
        bus.enable_i = 1'b0;
        step();
    endtask

    vec_t        vecs [8];
    logic [31:0] res;
    int          lat;

    initial begin
        vecs[0] = '{32'd6,         32'd7,         2'b00, 32'h0000_002A, 35};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 35};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 35};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 35};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 35};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 35};
        vecs[6] = '{32'h0000_0000, 32'h1234_5678, 2'b01, 32'h0000_0000, 1};
        vecs[7] = '{32'hFFFF_FFFF, 32'd5,         2'b00, 32'hFFFF_FFFB, 35};

        reset_n              = 1'b0;
        bus.enable_i         = 1'b0;
        bus.first_operand_i  = '0;
        bus.second_operand_i = '0;
        bus.op_i             = 2'b00;
        repeat (3) step();
        check("reset_hold", 64'(bus.hold_o), 64'd0);
        check("reset_result", 64'(bus.mul_result_o), 64'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, res, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            if (i == 0) begin
                // enable_i still high: result must hold and no restart may occur
                step();
                @(negedge clk);
                check("held_no_restart_hold", 64'(bus.hold_o), 64'd0);
                check("held_no_restart_result", 64'(bus.mul_result_o), 64'h2A);
            end
            release_op();
        end

        // Abort a MULHU at cycle 10, then a fresh request must be clean.
        bus.first_operand_i  = 32'hDEAD_BEEF;
        bus.second_operand_i = 32'h1234_5678;
        bus.op_i             = 2'b11;
        bus.enable_i         = 1'b1;
        repeat (10) step();
        bus.enable_i = 1'b0;
        step();
        check("abort_hold", 64'(bus.hold_o), 64'd0);
        run_op(32'd3, 32'd5, 2'b00, 1'b0, res, lat);
        check("after_abort_result", 64'(res), 64'hF);
        check("after_abort_latency", 64'(lat), 64'd35);
        release_op();

        // Reset in the middle of an operation.
        bus.first_operand_i  = 32'h0BAD_F00D;
        bus.second_operand_i = 32'hCAFE_0001;
        bus.op_i             = 2'b01;
        bus.enable_i         = 1'b1;
        repeat (20) step();
        reset_n      = 1'b0;
        bus.enable_i = 1'b0;
        #1;
        check("midreset_hold", 64'(bus.hold_o), 64'd0);
        check("midreset_result", 64'(bus.mul_result_o), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_reset_hold", 64'(bus.hold_o), 64'd0);
        check("post_reset_result", 64'(bus.mul_result_o), 64'd0);
        run_op(32'hFFFF_FFF9, 32'd3, 2'b01, 1'b0, res, lat);
        check("post_reset_op_result", 64'(res), 64'(model(32'hFFFF_FFF9, 32'd3, 2'b01)));
        check("post_reset_op_latency", 64'(lat), 64'd35);
        release_op();

        // Random operations; operands are scrambled while busy.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            case ($urandom_range(0, 7))
                0:       a = 32'd0;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'h8000_0000;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            op = 2'($urandom_range(0, 3));
            run_op(a, b, op, 1'b1, res, lat);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), 64'(res), 64'(model(a, b, op)));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(model_lat(a, b)));
            release_op();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mul
`default_nettype wire
